// File: rtl/serial_sub_ctrl_if.sv
// Request/result handshake and shared full-subtractor cell signals for serial_sub_ctrl.
// The master side is the requesting datapath together with the cell; the slave side is the controller.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             cell_x;
  logic             cell_y;
  logic             cell_bin;
  logic             cell_diff;
  logic             cell_borr;

  modport master (
    output start, a, b, bin, cell_diff, cell_borr,
    input  busy, done, diff, borrow_out, cell_x, cell_y, cell_bin
  );

  modport slave (
    input  start, a, b, bin, cell_diff, cell_borr,
    output busy, done, diff, borrow_out, cell_x, cell_y, cell_bin
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - bin controller: drives one external full-subtractor cell LSB first,
// one bit per clock, and assembles the result and final borrow.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               rst,
  serial_sub_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [WIDTH-1:0] res_next;

  // Cell bit enters at the MSB; after WIDTH shifts the first (LSB) bit sits at bit 0.
  assign res_next = {bus.cell_diff, res_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = bus.bin;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        borrow_d = bus.cell_borr;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_next;
          bout_d  = bus.cell_borr;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  // Cell stimulus is gated to zero outside RUN so the shared cell sees idle inputs.
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;
  assign bus.cell_x     = (state_q == RUN) & a_sh_q[0];
  assign bus.cell_y     = (state_q == RUN) & b_sh_q[0];
  assign bus.cell_bin   = (state_q == RUN) & borrow_q;

endmodule
